// File: rtl/rx_line_controller_pkg.sv
// Shared UART line-controller definitions: FSM encoding, ASCII control
// bytes and a small byte classifier used by the line controller.
package rx_line_controller_pkg;

    // ASCII control characters used for line editing
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    // Default line buffer geometry; LEN_W is wide enough for 0..DEPTH
    localparam int LINE_DEPTH_DEFAULT = 100;
    localparam int LEN_W              = 7;

    // Controller FSM encoding, kept as plain constants for legacy tools
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_STORE     = 3'd1;
    localparam logic [2:0] ST_ECHO_WAIT = 3'd2;
    localparam logic [2:0] ST_ECHO      = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // How a received byte is treated by the line editor
    typedef enum logic [1:0] {
        BYTE_ORDINARY = 2'd0,
        BYTE_BKSP     = 2'd1,
        BYTE_TERM     = 2'd2
    } byte_kind_t;

    // Terminator takes priority so a misconfigured TERM == BKSP still ends lines
    function automatic byte_kind_t classify_byte(
        input logic [7:0] data,
        input logic [7:0] term,
        input logic [7:0] bksp
    );
        byte_kind_t kind;
        kind = BYTE_ORDINARY;
        if (data == term) begin
            kind = BYTE_TERM;
        end else if (data == bksp) begin
            kind = BYTE_BKSP;
        end
        return kind;
    endfunction

endpackage

// File: rtl/rx_line_controller_line_buffer_ram.sv
// Line buffer storage: DEPTH x 8 memory with one write port and a
// registered read port (one cycle of read latency).
module line_buffer_ram #(
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic              Clk_100M,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:DEPTH-1];

    // Write port: the controller only writes while editing a line
    always_ff @(posedge Clk_100M) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port for the line consumer
    always_ff @(posedge Clk_100M) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rx_line_controller.sv
// Receive line controller: collects bytes from a UART receiver into a
// line buffer with backspace editing and echo, then holds the finished
// line for a consumer until it is released.
module rx_line_controller
    import rx_line_controller_pkg::*;
#(
    parameter int         DEPTH = LINE_DEPTH_DEFAULT,
    parameter logic [7:0] TERM  = ASCII_CR,
    parameter logic [7:0] BKSP  = ASCII_BS
) (
    input  logic             Clk_100M,
    input  logic             Reset,
    input  logic [7:0]       Rx_Data,
    input  logic             Rx_Ready,
    output logic             Rx_Ack,
    output logic             Rx_SoftReset,
    output logic [7:0]       Tx_Data,
    output logic             Tx_Send,
    input  logic             Tx_Busy,
    output logic             Line_Ready,
    output logic [LEN_W-1:0] Line_Length,
    input  logic [LEN_W-1:0] Rd_Addr,
    output logic [7:0]       Rd_Data,
    input  logic             Line_Release,
    output logic             Overflow,
    output logic [7:0]       LEDs
);

    logic [2:0]       state;
    logic             rx_ready_prev;
    logic [7:0]       rx_byte;
    logic [LEN_W-1:0] count;
    logic             line_ready;
    logic             overflow;
    logic             soft_reset;
    logic [7:0]       leds;
    logic [7:0]       tx_data;

    logic             arrival;
    byte_kind_t       kind;
    logic             buf_full;
    logic             wr_en;

    assign arrival  = Rx_Ready & ~rx_ready_prev;
    assign kind     = classify_byte(rx_byte, TERM, BKSP);
    assign buf_full = (count == LEN_W'(DEPTH));
    assign wr_en    = (state == ST_STORE) && (kind == BYTE_ORDINARY) && !buf_full;

    // Strobes are decoded from the state so each lasts exactly one state
    assign Rx_Ack       = (state == ST_STORE);
    assign Tx_Send      = (state == ST_ECHO);
    assign Tx_Data      = tx_data;
    assign Rx_SoftReset = soft_reset;
    assign Line_Ready   = line_ready;
    assign Line_Length  = count;
    assign Overflow     = overflow;
    assign LEDs         = leds;

    // Track Rx_Ready; resets high so a receiver idling high is not a new byte
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            rx_ready_prev <= 1'b1;
        end else begin
            rx_ready_prev <= Rx_Ready;
        end
    end

    // Line-editing FSM: accept, edit, echo, and hold a finished line
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state      <= ST_IDLE;
            rx_byte    <= 8'h00;
            count      <= '0;
            line_ready <= 1'b0;
            overflow   <= 1'b0;
            soft_reset <= 1'b0;
            leds       <= 8'h00;
            tx_data    <= 8'h00;
        end else begin
            soft_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arrival) begin
                        rx_byte <= Rx_Data;
                        state   <= ST_STORE;
                    end
                end

                ST_STORE: begin
                    if (arrival) begin
                        overflow <= 1'b1;
                    end
                    case (kind)
                        BYTE_TERM: begin
                            line_ready <= 1'b1;
                            state      <= ST_HOLD;
                        end
                        BYTE_BKSP: begin
                            if (count != '0) begin
                                count   <= count - LEN_W'(1);
                                tx_data <= rx_byte;
                                state   <= ST_ECHO_WAIT;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            if (!buf_full) begin
                                count   <= count + LEN_W'(1);
                                leds    <= rx_byte;
                                tx_data <= rx_byte;
                                state   <= ST_ECHO_WAIT;
                            end else begin
                                overflow <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end
                    endcase
                end

                ST_ECHO_WAIT: begin
                    if (arrival) begin
                        overflow <= 1'b1;
                    end
                    if (!Tx_Busy) begin
                        state <= ST_ECHO;
                    end
                end

                ST_ECHO: begin
                    if (arrival) begin
                        overflow <= 1'b1;
                    end
                    state <= ST_IDLE;
                end

                ST_HOLD: begin
                    if (Line_Release) begin
                        count      <= '0;
                        line_ready <= 1'b0;
                        overflow   <= 1'b0;
                        soft_reset <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (arrival) begin
                        overflow <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    line_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (LEN_W)
    ) u_line_buffer_ram (
        .Clk_100M (Clk_100M),
        .wr_en    (wr_en),
        .wr_addr  (count),
        .wr_data  (rx_byte),
        .rd_addr  (Rd_Addr),
        .rd_data  (Rd_Data)
    );

endmodule

// File: tb/tb_rx_line_controller.sv
// Testbench for rx_line_controller: a behavioural line model predicts
// echoes (queued as they are sent, popped when Tx_Send fires), line
// length, overflow, and the acknowledge / soft-reset pulse counts.
module tb_rx_line_controller;
    import rx_line_controller_pkg::*;

    localparam int DEPTH = 100;

    logic       Clk_100M = 1'b0;
    logic       Reset;
    logic [7:0] Rx_Data;
    logic       Rx_Ready;
    logic       Rx_Ack;
    logic       Rx_SoftReset;
    logic [7:0] Tx_Data;
    logic       Tx_Send;
    logic       Tx_Busy;
    logic       Line_Ready;
    logic [6:0] Line_Length;
    logic [6:0] Rd_Addr;
    logic [7:0] Rd_Data;
    logic       Line_Release;
    logic       Overflow;
    logic [7:0] LEDs;

    always #5 Clk_100M = ~Clk_100M;

    rx_line_controller #(
        .DEPTH (DEPTH),
        .TERM  (ASCII_CR),
        .BKSP  (ASCII_BS)
    ) dut (
        .Clk_100M     (Clk_100M),
        .Reset        (Reset),
        .Rx_Data      (Rx_Data),
        .Rx_Ready     (Rx_Ready),
        .Rx_Ack       (Rx_Ack),
        .Rx_SoftReset (Rx_SoftReset),
        .Tx_Data      (Tx_Data),
        .Tx_Send      (Tx_Send),
        .Tx_Busy      (Tx_Busy),
        .Line_Ready   (Line_Ready),
        .Line_Length  (Line_Length),
        .Rd_Addr      (Rd_Addr),
        .Rd_Data      (Rd_Data),
        .Line_Release (Line_Release),
        .Overflow     (Overflow),
        .LEDs         (LEDs)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] echoQueue [$];
    int         ackCount = 0;
    int         sendCount = 0;
    int         softResetCount = 0;
    int         expectedAcks = 0;
    int         expectedSends = 0;
    int         expectedSoftResets = 0;

    int         modelLen = 0;
    logic [7:0] modelBuf [0:DEPTH-1];
    logic       modelOverflow = 1'b0;
    logic       modelReady = 1'b0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and step just past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge Clk_100M);
        #1;
    endtask

    // Monitor pulses mid-cycle and score every echo against the queue
    always @(negedge Clk_100M) begin
        if (Rx_Ack) ackCount++;
        if (Rx_SoftReset) softResetCount++;
        if (Tx_Send) begin
            sendCount++;
            if (echoQueue.size() > 0) begin
                checkOutput("echo_data", 32'(Tx_Data), 32'(echoQueue.pop_front()));
            end else begin
                checkOutput("echo_queue_depth", 32'(echoQueue.size()), 32'd1);
            end
        end
    end

    // Update the line model for one byte, then drive a receiver frame
    task automatic applyStimulus(input logic [7:0] b, input bit dropExpected);
        if (dropExpected || modelReady) begin
            modelOverflow = 1'b1;
        end else begin
            expectedAcks++;
            if (b == ASCII_CR) begin
                modelReady = 1'b1;
            end else if (b == ASCII_BS) begin
                if (modelLen > 0) begin
                    modelLen--;
                    echoQueue.push_back(b);
                    expectedSends++;
                end
            end else if (modelLen < DEPTH) begin
                modelBuf[modelLen] = b;
                modelLen++;
                echoQueue.push_back(b);
                expectedSends++;
            end else begin
                modelOverflow = 1'b1;
            end
        end
        Rx_Data  = b;
        Rx_Ready = 1'b0;
        tick(2);
        Rx_Ready = 1'b1;
        tick(6);
    endtask

    // Pulse Line_Release for one cycle; only a held line is freed
    task automatic releaseLine();
        Line_Release = 1'b1;
        tick(1);
        Line_Release = 1'b0;
        if (modelReady) begin
            modelLen      = 0;
            modelReady    = 1'b0;
            modelOverflow = 1'b0;
            expectedSoftResets++;
        end
        tick(2);
    endtask

    // Compare line status outputs with the model
    task automatic checkLine(input string prefix);
        checkOutput({prefix, "_len"}, 32'(Line_Length), 32'(modelLen));
        checkOutput({prefix, "_ready"}, 32'(Line_Ready), 32'(modelReady));
        checkOutput({prefix, "_ovf"}, 32'(Overflow), 32'(modelOverflow));
    endtask

    // Read one buffer byte through the registered port
    task automatic checkRead(input string tag, input int addr);
        Rd_Addr = 7'(addr);
        tick(1);
        checkOutput(tag, 32'(Rd_Data), 32'(modelBuf[addr]));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         sendBefore;
        int         ackBefore;
        int         softBefore;
        logic [7:0] b;

        Reset        = 1'b1;
        Rx_Data      = 8'h00;
        Rx_Ready     = 1'b1;
        Tx_Busy      = 1'b0;
        Rd_Addr      = 7'd0;
        Line_Release = 1'b0;
        tick(3);
        Reset = 1'b0;
        tick(3);

        $display("[TB] reset state");
        checkLine("reset");
        checkOutput("reset_leds", 32'(LEDs), 32'd0);
        checkOutput("reset_txdata", 32'(Tx_Data), 32'd0);
        checkOutput("reset_txsend", 32'(Tx_Send), 32'd0);
        checkOutput("reset_softreset", 32'(Rx_SoftReset), 32'd0);
        checkOutput("reset_no_false_edge", 32'(ackCount), 32'd0);

        $display("[TB] basic line A B CR");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b0);
        checkOutput("ab_leds", 32'(LEDs), 32'h42);
        applyStimulus(ASCII_CR, 1'b0);
        checkLine("ab");
        checkRead("ab_rd0", 0);
        checkRead("ab_rd1", 1);
        releaseLine();
        checkLine("ab_rel");
        checkOutput("ab_softreset", 32'(softResetCount), 32'(expectedSoftResets));

        $display("[TB] backspace editing");
        applyStimulus(8'h41, 1'b0);
        applyStimulus(ASCII_BS, 1'b0);
        applyStimulus(8'h43, 1'b0);
        applyStimulus(ASCII_CR, 1'b0);
        checkLine("bs");
        checkRead("bs_rd0", 0);
        releaseLine();
        sendBefore = sendCount;
        applyStimulus(ASCII_BS, 1'b0);
        checkLine("bs_empty");
        checkOutput("bs_empty_noecho", 32'(sendCount), 32'(sendBefore));

        $display("[TB] buffer full");
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'(97 + (i % 26));
            applyStimulus(b, 1'b0);
            if (i == DEPTH - 1) checkLine("full_100");
        end
        checkLine("full_101");
        applyStimulus(ASCII_CR, 1'b0);
        checkLine("full_cr");
        checkRead("full_rd0", 0);
        checkRead("full_rd99", DEPTH - 1);
        releaseLine();
        checkLine("full_rel");

        $display("[TB] echo held off by Tx_Busy");
        Tx_Busy = 1'b1;
        sendBefore = sendCount;
        applyStimulus(8'h58, 1'b0);
        applyStimulus(8'h59, 1'b1);
        tick(34);
        checkOutput("busy_no_send", 32'(sendCount), 32'(sendBefore));
        checkOutput("busy_send_low", 32'(Tx_Send), 32'd0);
        Tx_Busy = 1'b0;
        tick(1);
        checkOutput("busy_send_after_fall", 32'(Tx_Send), 32'd1);
        tick(3);
        checkLine("busy");
        applyStimulus(ASCII_CR, 1'b0);
        releaseLine();
        checkLine("busy_rel");

        $display("[TB] release outside HOLD is ignored");
        softBefore = softResetCount;
        applyStimulus(8'h4D, 1'b0);
        releaseLine();
        checkLine("early_rel");
        checkOutput("early_rel_softreset", 32'(softResetCount), 32'(softBefore));
        applyStimulus(ASCII_CR, 1'b0);
        releaseLine();

        $display("[TB] release and arrival in the same HOLD cycle");
        applyStimulus(8'h51, 1'b0);
        applyStimulus(ASCII_CR, 1'b0);
        applyStimulus(8'h52, 1'b0);
        checkLine("hold_drop");
        ackBefore = ackCount;
        softBefore = softResetCount;
        Rx_Data  = 8'h53;
        Rx_Ready = 1'b0;
        tick(2);
        Rx_Ready     = 1'b1;
        Line_Release = 1'b1;
        tick(1);
        Line_Release  = 1'b0;
        modelLen      = 0;
        modelReady    = 1'b0;
        modelOverflow = 1'b0;
        expectedSoftResets++;
        tick(4);
        checkLine("simul");
        checkOutput("simul_softreset", 32'(softResetCount - softBefore), 32'd1);
        checkOutput("simul_no_ack", 32'(ackCount), 32'(ackBefore));

        $display("[TB] reset during ECHO_WAIT");
        Tx_Busy = 1'b1;
        applyStimulus(8'h4B, 1'b0);
        sendBefore = sendCount;
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        expectedSends = expectedSends - echoQueue.size();
        echoQueue.delete();
        modelLen      = 0;
        modelReady    = 1'b0;
        modelOverflow = 1'b0;
        checkLine("rst_mid");
        checkOutput("rst_mid_leds", 32'(LEDs), 32'd0);
        checkOutput("rst_mid_txdata", 32'(Tx_Data), 32'd0);
        checkOutput("rst_mid_ack", 32'(Rx_Ack), 32'd0);
        Tx_Busy = 1'b0;
        tick(10);
        checkOutput("rst_mid_no_send", 32'(sendCount), 32'(sendBefore));
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(ASCII_CR, 1'b0);
        checkLine("rst_z");
        checkRead("rst_z_rd0", 0);
        releaseLine();

        tick(5);
        checkOutput("echo_queue_empty", 32'(echoQueue.size()), 32'd0);
        checkOutput("total_sends", 32'(sendCount), 32'(expectedSends));
        checkOutput("total_acks", 32'(ackCount), 32'(expectedAcks));
        checkOutput("total_softresets", 32'(softResetCount), 32'(expectedSoftResets));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
